// File: rtl/ethernet_pkg.sv
// Shared definitions for the Ethernet receive filter: FSM encoding, address
// constants, CRC-32 parameters and a destination-address byte selector.
package ethernet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DST,
    ST_SRC,
    ST_TYPE,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  localparam logic [47:0] BCAST_ADDR    = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam int          HDR_LEN       = 14;
  localparam logic [3:0]  FCS_LEN       = 4'd4;

  // Byte idx of a 48-bit address, transmitted most significant byte first.
  function automatic logic [7:0] addr_byte(input logic [47:0] addr, input logic [3:0] idx);
    logic [47:0] shifted;
    shifted = addr << {idx, 3'b000};
    return shifted[47:40];
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// One-byte CRC-32 step, combinational. Data bits enter LSB first into an
// MSB-first register, so the register is the bit-reverse of the usual reflected form.
module crc32_d8
  import ethernet_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[31] ^ data[i]) crc_out = {crc_out[30:0], 1'b0} ^ CRC_POLY;
      else                       crc_out = {crc_out[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/ethernet_rx_filter.sv
// Destination-address filter for received Ethernet frames: strips the header,
// forwards payload bytes. Define ETH_RX_FCS_CHECK_EN to add FCS checking/stripping.
module ethernet_rx_filter
  import ethernet_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR     = 48'h02_00_00_00_00_01,
  parameter bit          ACCEPT_BCAST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_ready,
  input  logic [7:0]  frame,
  input  logic        frame_end,
  output logic        pl_valid,
  output logic [7:0]  pl_data,
  output logic [15:0] ethertype,
  output logic        frame_done,
  output logic        frame_good,
  output logic        frame_dropped,
  output state_t      state
);

  // Handshake: frame_ready and pl_valid are one-cycle strobes with no
  // backpressure; a byte is taken/offered on every cycle its strobe is high.
  state_t      state_next;
  logic [3:0]  cnt, cnt_next;
  logic        ucast_hit, bcast_hit, ucast_next, bcast_next;
  logic        byte_ucast, byte_bcast;
  logic [15:0] ethertype_next;
  logic        emit;
  logic [7:0]  emit_data;
  logic        done_next, good_next, drop_next;

`ifdef ETH_RX_FCS_CHECK_EN
  logic [31:0] crc, crc_calc, crc_next;
  logic [31:0] dly;

  crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (frame),
    .crc_out (crc_calc)
  );

  assign crc_next = frame_ready ? crc_calc : crc;
`endif

  assign byte_ucast = (frame == addr_byte(MAC_ADDR, cnt));
  assign byte_bcast = ACCEPT_BCAST && (frame == addr_byte(BCAST_ADDR, cnt));

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    ucast_next     = ucast_hit;
    bcast_next     = bcast_hit;
    ethertype_next = ethertype;
    emit           = 1'b0;
    emit_data      = frame;
    done_next      = 1'b0;
    good_next      = 1'b0;
    drop_next      = 1'b0;
    if (frame_ready) begin
      case (state)
        ST_IDLE, ST_DST: begin
          ucast_next = (state == ST_IDLE || ucast_hit) && byte_ucast;
          bcast_next = (state == ST_IDLE || bcast_hit) && byte_bcast;
          cnt_next   = cnt + 4'd1;
          if (cnt == 4'd5) state_next = (ucast_next || bcast_next) ? ST_SRC : ST_DROP;
          else             state_next = ST_DST;
        end
        ST_SRC: begin
          cnt_next = cnt + 4'd1;
          if (cnt == 4'd11) state_next = ST_TYPE;
        end
        ST_TYPE: begin
          cnt_next = cnt + 4'd1;
          if (cnt == 4'(HDR_LEN - 1)) begin
            ethertype_next[7:0] = frame;
            cnt_next            = '0;
            state_next          = ST_PAYLOAD;
          end else begin
            ethertype_next[15:8] = frame;
          end
        end
        ST_PAYLOAD: begin
`ifdef ETH_RX_FCS_CHECK_EN
          // cnt tracks delay-line fill; once full each new byte pushes out the oldest
          if (cnt == FCS_LEN) begin
            emit      = 1'b1;
            emit_data = dly[31:24];
          end else begin
            cnt_next = cnt + 4'd1;
          end
`else
          emit = 1'b1;
`endif
        end
        default: ;
      endcase
    end
    // End handling looks at the post-byte state so a coincident byte counts.
    if (frame_end && state_next != ST_IDLE) begin
      if (state_next == ST_PAYLOAD) begin
`ifdef ETH_RX_FCS_CHECK_EN
        if (cnt_next == FCS_LEN) begin
          done_next = 1'b1;
          good_next = (crc_next == CRC_RESIDUE);
        end else begin
          drop_next = 1'b1;
        end
`else
        done_next = 1'b1;
        good_next = 1'b1;
`endif
      end else begin
        drop_next = 1'b1;
      end
      state_next = ST_IDLE;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt           <= '0;
      ucast_hit     <= 1'b0;
      bcast_hit     <= 1'b0;
      ethertype     <= '0;
      pl_valid      <= 1'b0;
      pl_data       <= '0;
      frame_done    <= 1'b0;
      frame_good    <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      cnt           <= cnt_next;
      ucast_hit     <= ucast_next;
      bcast_hit     <= bcast_next;
      ethertype     <= ethertype_next;
      pl_valid      <= emit;
      if (emit) pl_data <= emit_data;
      frame_done    <= done_next;
      frame_good    <= good_next;
      frame_dropped <= drop_next;
    end
  end

`ifdef ETH_RX_FCS_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      crc <= CRC_INIT;
      dly <= '0;
    end else begin
      crc <= (state_next == ST_IDLE) ? CRC_INIT : crc_next;
      if (frame_ready && state == ST_PAYLOAD) dly <= {dly[23:0], frame};
    end
  end
`endif

endmodule
